// File: rtl/ssg_scan_reader.sv
// ssg_scan_reader
// Reads a multiplexed 4-digit seven-segment display bus and reconstructs the
// displayed BCD number. A digit is taken once its {an, ssg} pattern has been
// stable for STABLE enabled samples. When all four digits have been captured
// the frame is published.
//
// Ports:
//   clk     rising-edge clock
//   reset   synchronous active-high reset (priority over enable)
//   enable  sample qualifier; low freezes all state
//   ssg     segment pattern, ssg[6]=a .. ssg[0]=g
//   an      one-hot digit select, an[0]=units
//   value   last complete frame, 4 BCD digits, value[3:0]=units
//   valid   one-cycle pulse: value updated this cycle
//   err     one-cycle pulse: invalid pattern accepted, frame discarded
//   seen    digits captured in the current frame
module ssg_scan_reader #(
    parameter int STABLE = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [6:0]  ssg,
    input  logic [3:0]  an,
    output logic [15:0] value,
    output logic        valid,
    output logic        err,
    output logic [3:0]  seen
);

    typedef enum logic [1:0] {COLLECT, PUBLISH, FAULT} state_e;

    state_e      state_q, state_d;
    logic [10:0] sample_q, sample_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] shadow_q, shadow_d;
    logic [15:0] value_q, value_d;
    logic [3:0]  seen_q, seen_d;

    logic [10:0] cur;
    logic        an_onehot, match, accept, dig_ok, publish_go, fault_go;
    logic [3:0]  dig_bcd;

    function automatic logic [4:0] decode(input logic [6:0] s);
        logic [4:0] r;
        case (s)
            7'h7E:   r = {1'b1, 4'd0};
            7'h30:   r = {1'b1, 4'd1};
            7'h6D:   r = {1'b1, 4'd2};
            7'h79:   r = {1'b1, 4'd3};
            7'h33:   r = {1'b1, 4'd4};
            7'h5B:   r = {1'b1, 4'd5};
            7'h5F:   r = {1'b1, 4'd6};
            7'h70:   r = {1'b1, 4'd7};
            7'h7F:   r = {1'b1, 4'd8};
            7'h7B:   r = {1'b1, 4'd9};
            default: r = 5'd0;
        endcase
        return r;
    endfunction

    assign cur       = {an, ssg};
    assign an_onehot = (an != 4'b0) && ((an & (an - 4'd1)) == 4'b0);
    assign match     = (cur == sample_q);
    assign {dig_ok, dig_bcd} = decode(ssg);

    // The counter holds (number of matching samples - 1), so the STABLE-th
    // identical sample arrives while it reads STABLE-2. Saturation keeps it
    // from ever revisiting that value, giving one acceptance per window.
    assign accept     = enable && an_onehot && match && (cnt_q == 4'(STABLE - 2));
    assign fault_go   = accept && !dig_ok;
    assign publish_go = enable && (seen_q == 4'hF);

    // Stability tracking
    always_comb begin
        sample_d = sample_q;
        cnt_d    = cnt_q;
        if (enable) begin
            sample_d = cur;
            if (!an_onehot || !match) cnt_d = 4'd0;
            else if (cnt_q != 4'hF)   cnt_d = cnt_q + 4'd1;
        end
    end

    // Frame assembly. Publishing clears seen before a same-edge capture is
    // merged in, so that capture starts the next frame.
    always_comb begin
        shadow_d = shadow_q;
        seen_d   = seen_q;
        value_d  = value_q;
        if (publish_go && !fault_go) begin
            value_d = shadow_q;
            seen_d  = 4'b0;
        end
        if (accept) begin
            if (dig_ok) begin
                for (int i = 0; i < 4; i++)
                    if (an[i]) shadow_d[i*4 +: 4] = dig_bcd;
                seen_d = seen_d | an;
            end else begin
                shadow_d = 16'b0;
                seen_d   = 4'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sample_q <= '0;
            cnt_q    <= '0;
            shadow_q <= '0;
            seen_q   <= '0;
            value_q  <= '0;
        end else begin
            sample_q <= sample_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            seen_q   <= seen_d;
            value_q  <= value_d;
        end
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (reset) state_q <= COLLECT;
        else       state_q <= state_d;
    end

    // FSM: next state. PUBLISH/FAULT last exactly one cycle; entry only
    // happens on enabled edges, which is what defers a pending pulse.
    always_comb begin
        state_d = COLLECT;
        if (fault_go)        state_d = FAULT;
        else if (publish_go) state_d = PUBLISH;
    end

    // FSM: outputs
    always_comb begin
        valid = (state_q == PUBLISH);
        err   = (state_q == FAULT);
    end

    assign value = value_q;
    assign seen  = seen_q;

endmodule

// File: tb/tb_ssg_scan_reader.sv
module tb_ssg_scan_reader;
    localparam int STABLE = 4;

    logic        clk = 1'b0;
    logic        reset, enable;
    logic [6:0]  ssg;
    logic [3:0]  an;
    logic [15:0] value;
    logic        valid, err;
    logic [3:0]  seen;

    ssg_scan_reader #(.STABLE(STABLE)) dut (
        .clk(clk), .reset(reset), .enable(enable), .ssg(ssg), .an(an),
        .value(value), .valid(valid), .err(err), .seen(seen)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    int nval = 0, nerr = 0;

    // Reference model state
    logic [6:0]  pat [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
                              7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};
    logic [10:0] hist [$];
    logic [3:0]  m_sh [4];
    logic [15:0] m_value;
    logic [3:0]  m_seen;
    logic        m_valid, m_err;

    function automatic int mdec(input logic [6:0] s);
        for (int i = 0; i < 10; i++) if (pat[i] == s) return i;
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic [3:0] a, input logic [6:0] s,
                              input logic e, input logic r);
        int run, d, slot;
        logic acc, bad;
        if (r) begin
            hist.delete();
            m_value = 0; m_seen = 0; m_valid = 0; m_err = 0;
            for (int i = 0; i < 4; i++) m_sh[i] = 0;
            return;
        end
        m_valid = 0; m_err = 0;
        if (!e) return;
        hist.push_back({a, s});
        if (hist.size() > 20) void'(hist.pop_front());
        run = 0;
        for (int i = hist.size() - 1; i >= 0; i--) begin
            if (hist[i] != {a, s}) break;
            run++;
        end
        acc = ($countones(a) == 1) && (run == STABLE);
        d   = mdec(s);
        bad = acc && (d < 0);
        if (m_seen == 4'hF && !bad) begin
            m_value = {m_sh[3], m_sh[2], m_sh[1], m_sh[0]};
            m_seen  = 0;
            m_valid = 1;
        end
        if (acc) begin
            if (bad) begin
                m_seen = 0; m_err = 1;
                for (int i = 0; i < 4; i++) m_sh[i] = 0;
            end else begin
                slot = 0;
                for (int i = 0; i < 4; i++) if (a[i]) slot = i;
                m_sh[slot] = d[3:0];
                m_seen = m_seen | a;
            end
        end
    endtask

    task automatic step(input logic [3:0] a, input logic [6:0] s,
                        input logic e, input logic r);
        an = a; ssg = s; enable = e; reset = r;
        @(posedge clk);
        model_edge(a, s, e, r);
        #1;
        chk("valid", {15'b0, valid}, {15'b0, m_valid});
        chk("err",   {15'b0, err},   {15'b0, m_err});
        chk("seen",  {12'b0, seen},  {12'b0, m_seen});
        chk("value", value, m_value);
        chk("excl",  {15'b0, valid & err}, 16'b0);
        if (valid) nval++;
        if (err)   nerr++;
    endtask

    task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n);
        for (int i = 0; i < n; i++) step(a, s, 1'b1, 1'b0);
    endtask

    // n enabled samples, each followed by a disabled cycle carrying garbage
    task automatic hold_t(input logic [3:0] a, input logic [6:0] s, input int n);
        for (int i = 0; i < n; i++) begin
            step(a, s, 1'b1, 1'b0);
            step(4'($urandom), 7'($urandom), 1'b0, 1'b0);
        end
    endtask

    initial begin
        int v0, e0;
        logic [3:0] ra;
        logic [6:0] rs;
        an = 0; ssg = 0; enable = 0; reset = 1;

        // Reset state
        step(4'h0, 7'h00, 1'b1, 1'b1);
        step(4'h0, 7'h00, 1'b0, 1'b1);
        chk("rst_value", value, 16'h0000);
        chk("rst_seen", {12'b0, seen}, 16'h0);

        // Basic full frame
        v0 = nval;
        hold(4'h1, 7'h5B, 6); chk("f1_seen1", {12'b0, seen}, 16'h1);
        hold(4'h2, 7'h79, 6); chk("f1_seen2", {12'b0, seen}, 16'h3);
        hold(4'h4, 7'h30, 6); chk("f1_seen3", {12'b0, seen}, 16'h7);
        hold(4'h8, 7'h7F, 4); chk("f1_seen4", {12'b0, seen}, 16'hF);
        step(4'h8, 7'h7F, 1'b1, 1'b0);
        chk("f1_valid", {15'b0, valid}, 16'h1);
        chk("f1_value", value, 16'h8135);
        hold(4'h8, 7'h7F, 1);
        hold(4'h0, 7'h00, 2);
        chk("f1_npulse", 16'(nval - v0), 16'd1);

        // Long hold accepted once
        v0 = nval; e0 = nerr;
        hold(4'h1, 7'h5B, 20);
        chk("hold_seen", {12'b0, seen}, 16'h1);
        chk("hold_nval", 16'(nval - v0), 16'd0);
        chk("hold_nerr", 16'(nerr - e0), 16'd0);

        // Invalid pattern discards the frame
        hold(4'h1, 7'h33, 6);
        hold(4'h2, 7'h6D, 6);
        hold(4'h4, 7'h00, 4);
        chk("bad_err", {15'b0, err}, 16'h1);
        chk("bad_seen", {12'b0, seen}, 16'h0);
        chk("bad_value", value, 16'h8135);
        hold(4'h4, 7'h00, 3);
        chk("bad_nerr", 16'(nerr - e0), 16'd1);

        // Short glitch is never captured
        hold(4'h1, 7'h7E, 3);
        chk("gl_seen0", {12'b0, seen}, 16'h0);
        hold(4'h1, 7'h30, 4);
        chk("gl_seen1", {12'b0, seen}, 16'h1);
        hold(4'h2, 7'h7E, 5); hold(4'h4, 7'h6D, 5); hold(4'h8, 7'h79, 5);
        hold(4'h0, 7'h00, 2);
        chk("gl_value", value, 16'h3201);

        // Non-one-hot selects never accept
        v0 = nval;
        hold(4'h3, 7'h30, 10);
        hold(4'h0, 7'h30, 10);
        chk("oh_seen", {12'b0, seen}, 16'h0);
        chk("oh_nval", 16'(nval - v0), 16'd0);

        // Reset mid-frame, then a fresh frame
        hold(4'h1, 7'h30, 5); hold(4'h2, 7'h6D, 5); hold(4'h4, 7'h79, 5);
        step(4'h4, 7'h79, 1'b1, 1'b1);
        chk("mr_value", value, 16'h0);
        chk("mr_seen", {12'b0, seen}, 16'h0);
        v0 = nval;
        hold(4'h1, 7'h33, 5); hold(4'h2, 7'h7B, 5); hold(4'h4, 7'h70, 5);
        hold(4'h8, 7'h5F, 5); hold(4'h0, 7'h00, 2);
        chk("mr_newval", value, 16'h6794);
        chk("mr_nval", 16'(nval - v0), 16'd1);

        // Reset on the publish edge suppresses the pulse
        v0 = nval;
        hold(4'h1, 7'h30, 5); hold(4'h2, 7'h30, 5); hold(4'h4, 7'h30, 5);
        hold(4'h8, 7'h30, 4);
        step(4'h8, 7'h30, 1'b1, 1'b1);
        hold(4'h0, 7'h00, 2);
        chk("rp_nval", 16'(nval - v0), 16'd0);
        chk("rp_value", value, 16'h0);

        // Enable toggling gives the same result as the enable-high frame
        v0 = nval;
        hold_t(4'h1, 7'h33, 5); hold_t(4'h2, 7'h7B, 5); hold_t(4'h4, 7'h70, 5);
        hold_t(4'h8, 7'h5F, 5); hold(4'h0, 7'h00, 2);
        chk("tg_value", value, 16'h6794);
        chk("tg_nval", 16'(nval - v0), 16'd1);

        // Randomized traffic against the model
        for (int it = 0; it < 300; it++) begin
            int n;
            case ($urandom_range(0, 9))
                0:       ra = 4'($urandom);
                default: ra = 4'(1 << $urandom_range(0, 3));
            endcase
            rs = ($urandom_range(0, 11) == 0) ? 7'($urandom) : pat[$urandom_range(0, 9)];
            n  = $urandom_range(1, 7);
            for (int k = 0; k < n; k++)
                step(ra, rs, ($urandom_range(0, 4) != 0), ($urandom_range(0, 99) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
